i2c_target_core: RTL and testbench

Bit-level I2C target (slave) engine: the responder counterpart of the team's I2C controller core. It watches filtered SDA/SCL, detects START/STOP, matches a 7-bit address, receives write bytes and transmits read bytes, and hands byte-wide data to a register/FIFO front end over simple valid/request handshakes. It drives SDA and SCL only as open-drain pull-downs (output 0 = pull low, 1 = release) and stretches SCL while waiting for read data.

---
 rtl/i2c_target_core.sv | 249 ++++++++++++++++++++++++
 tb/tb_i2c_target_core.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_core.sv
// Bit-level I2C target: START/STOP detect, 7-bit address match, byte RX/TX over valid/request handshakes.
// Latency: line drives and event pulses one clk after the sampled bus edge; SCL stretched while tx_req waits on tx_valid.
module i2c_target_core #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sda_i,
    input  logic       scl_i,
    output logic       sda_o,
    output logic       scl_o,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_req,
    output logic       busy,
    output logic       rw,
    output logic       start_det,
    output logic       stop_det,
    output logic       nack_det
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX_LOAD,
        ST_TX,
        ST_TX_ACK,
        ST_IGNORE
    } state_t;

    state_t     state, state_nxt;
    logic       sda_d1, scl_d1;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift, shift_nxt;
    // byte_end: 8th bit sampled in ADDR/RX; in TX_ACK it marks a controller ACK seen
    logic       byte_end, byte_end_nxt;
    logic       acked, acked_nxt;
    logic       loaded, loaded_nxt;
    logic       sda_o_nxt, scl_o_nxt;
    logic [7:0] rx_data_nxt;
    logic       rx_valid_nxt, tx_req_nxt, busy_nxt, rw_nxt;
    logic       start_det_nxt, stop_det_nxt, nack_det_nxt;

    logic scl_rise, scl_fall, start_cond, stop_cond;
    assign scl_rise   = scl_i & ~scl_d1;
    assign scl_fall   = ~scl_i & scl_d1;
    assign start_cond = scl_i & scl_d1 & sda_d1 & ~sda_i;
    assign stop_cond  = scl_i & scl_d1 & ~sda_d1 & sda_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sda_d1    <= 1'b1;
            scl_d1    <= 1'b1;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            byte_end  <= 1'b0;
            acked     <= 1'b0;
            loaded    <= 1'b0;
            sda_o     <= 1'b1;
            scl_o     <= 1'b1;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            nack_det  <= 1'b0;
        end else begin
            state     <= state_nxt;
            sda_d1    <= sda_i;
            scl_d1    <= scl_i;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            byte_end  <= byte_end_nxt;
            acked     <= acked_nxt;
            loaded    <= loaded_nxt;
            sda_o     <= sda_o_nxt;
            scl_o     <= scl_o_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            tx_req    <= tx_req_nxt;
            busy      <= busy_nxt;
            rw        <= rw_nxt;
            start_det <= start_det_nxt;
            stop_det  <= stop_det_nxt;
            nack_det  <= nack_det_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        byte_end_nxt  = byte_end;
        acked_nxt     = acked;
        loaded_nxt    = loaded;
        sda_o_nxt     = sda_o;
        scl_o_nxt     = scl_o;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        tx_req_nxt    = tx_req;
        busy_nxt      = busy;
        rw_nxt        = rw;
        start_det_nxt = 1'b0;
        stop_det_nxt  = 1'b0;
        nack_det_nxt  = 1'b0;

        // Bus conditions override everything, including an active stretch
        if (stop_cond) begin
            state_nxt    = ST_IDLE;
            stop_det_nxt = 1'b1;
            busy_nxt     = 1'b0;
            sda_o_nxt    = 1'b1;
            scl_o_nxt    = 1'b1;
            tx_req_nxt   = 1'b0;
            loaded_nxt   = 1'b0;
        end else if (start_cond) begin
            state_nxt     = ST_ADDR;
            start_det_nxt = 1'b1;
            bit_cnt_nxt   = 3'd0;
            byte_end_nxt  = 1'b0;
            busy_nxt      = 1'b0;
            sda_o_nxt     = 1'b1;
            scl_o_nxt     = 1'b1;
            tx_req_nxt    = 1'b0;
            loaded_nxt    = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sda_o_nxt = 1'b1;
                    scl_o_nxt = 1'b1;
                end
                ST_ADDR, ST_RX: begin
                    if (scl_rise) begin
                        shift_nxt   = {shift[6:0], sda_i};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            byte_end_nxt = 1'b1;
                    end else if (scl_fall && byte_end) begin
                        byte_end_nxt = 1'b0;
                        if (state == ST_ADDR) begin
                            if (shift[7:1] == ADDR) begin
                                state_nxt = ST_ADDR_ACK;
                                sda_o_nxt = 1'b0;
                                busy_nxt  = 1'b1;
                                rw_nxt    = shift[0];
                            end else begin
                                state_nxt = ST_IGNORE;
                            end
                        end else begin
                            rx_data_nxt  = shift;
                            rx_valid_nxt = 1'b1;
                            acked_nxt    = rx_ready;
                            sda_o_nxt    = ~rx_ready;
                            state_nxt    = ST_RX_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_o_nxt    = 1'b1;
                        bit_cnt_nxt  = 3'd0;
                        byte_end_nxt = 1'b0;
                        if (rw) begin
                            state_nxt  = ST_TX_LOAD;
                            scl_o_nxt  = 1'b0;
                            tx_req_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_RX;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_o_nxt = 1'b1;
                        if (acked) begin
                            state_nxt = ST_RX;
                        end else begin
                            state_nxt = ST_IGNORE;
                            busy_nxt  = 1'b0;
                        end
                    end
                end
                ST_TX_LOAD: begin
                    // Release SCL one clk after loading so bit 7 has setup time
                    if (loaded) begin
                        scl_o_nxt   = 1'b1;
                        loaded_nxt  = 1'b0;
                        bit_cnt_nxt = 3'd0;
                        state_nxt   = ST_TX;
                    end else if (tx_req && tx_valid) begin
                        shift_nxt  = tx_data;
                        sda_o_nxt  = tx_data[7];
                        tx_req_nxt = 1'b0;
                        loaded_nxt = 1'b1;
                    end
                end
                ST_TX: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_o_nxt    = 1'b1;
                            bit_cnt_nxt  = 3'd0;
                            byte_end_nxt = 1'b0;
                            state_nxt    = ST_TX_ACK;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                            sda_o_nxt   = shift[6];
                            shift_nxt   = {shift[6:0], 1'b0};
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_i) begin
                            nack_det_nxt = 1'b1;
                            busy_nxt     = 1'b0;
                            state_nxt    = ST_IGNORE;
                        end else begin
                            byte_end_nxt = 1'b1;
                        end
                    end else if (scl_fall && byte_end) begin
                        byte_end_nxt = 1'b0;
                        state_nxt    = ST_TX_LOAD;
                        scl_o_nxt    = 1'b0;
                        tx_req_nxt   = 1'b1;
                    end
                end
                ST_IGNORE: begin
                    sda_o_nxt  = 1'b1;
                    scl_o_nxt  = 1'b1;
                    busy_nxt   = 1'b0;
                    tx_req_nxt = 1'b0;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_core.sv
// Bench for i2c_target_core: open-drain bus model with a behavioural controller, table vectors and random transactions.
module tb_i2c_target_core;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       sda_m = 1'b1, scl_m = 1'b1;
    logic       sda_i, scl_i, sda_o, scl_o;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_req, busy, rw, start_det, stop_det, nack_det;

    assign sda_i = sda_m & sda_o;
    assign scl_i = scl_m & scl_o;

    i2c_target_core #(.ADDR(7'h50)) dut (
        .clk(clk), .reset(reset), .sda_i(sda_i), .scl_i(scl_i),
        .sda_o(sda_o), .scl_o(scl_o), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_req(tx_req),
        .busy(busy), .rw(rw), .start_det(start_det), .stop_det(stop_det), .nack_det(nack_det)
    );

    int vectors = 0;
    int miscompares = 0;

    // Bus-side observers and the read-data supplier
    logic [7:0] rx_got[$];
    int n_start = 0, n_stop = 0, n_nack = 0, n_sda_low = 0, n_busy = 0;
    int stretch_cur = 0, stretch_len = 0;
    logic stretch_sda = 1'b1;
    logic [7:0] tx_buf [64];
    int tx_wr = 0, tx_rd = 0, tx_delay = 0, wait_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) rx_got.push_back(rx_data);
            if (start_det) n_start++;
            if (stop_det) n_stop++;
            if (nack_det) n_nack++;
            if (!sda_o) n_sda_low++;
            if (busy) n_busy++;
        end
        if (!scl_o) begin
            stretch_cur++;
            stretch_sda = sda_o;
        end else if (stretch_cur != 0) begin
            stretch_len = stretch_cur;
            stretch_cur = 0;
        end
        if (tx_valid && !tx_req) begin
            tx_valid = 1'b0;
        end else if (!tx_req) begin
            wait_cnt = 0;
        end else if (!tx_valid && tx_rd < tx_wr) begin
            if (wait_cnt >= tx_delay) begin
                tx_data  = tx_buf[tx_rd];
                tx_rd++;
                tx_valid = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_scl_high();
        int k = 0;
        while (scl_i !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL scl_timeout: scl held low %0d clk, required release", k);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; clks(4);
        scl_m = 1'b1; wait_scl_high(); clks(4);
        sda_m = 1'b0; clks(4);
        scl_m = 1'b0; clks(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; clks(4);
        scl_m = 1'b1; wait_scl_high(); clks(4);
        sda_m = 1'b1; clks(8);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; clks(4);
        scl_m = 1'b1; wait_scl_high(); clks(4);
        scl_m = 1'b0; clks(4);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; clks(4);
        scl_m = 1'b1; wait_scl_high(); clks(4);
        b = sda_i;
        scl_m = 1'b0; clks(4);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(input logic last, output logic [7:0] b);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            read_bit(x);
            b[i] = x;
        end
        write_bit(last);
    endtask

    task automatic do_write(input logic [6:0] a, input int n, input logic [31:0] dat,
                            input logic [3:0] rdy, output logic aack, output logic busy_at,
                            output logic [3:0] backs);
        logic k;
        backs = 4'b0000;
        i2c_start();
        write_byte({a, 1'b0}, aack);
        busy_at = busy;
        for (int i = 0; i < n; i++) begin
            rx_ready = rdy[i];
            write_byte(dat[31-8*i -: 8], k);
            backs[i] = k;
        end
        rx_ready = 1'b1;
        i2c_stop();
    endtask

    task automatic do_read(input logic [6:0] a, input int n, output logic aack, output logic [31:0] got);
        logic [7:0] b;
        got = 32'h0;
        i2c_start();
        write_byte({a, 1'b1}, aack);
        if (aack) begin
            for (int i = 0; i < n; i++) begin
                read_byte(i == n - 1, b);
                got[31-8*i -: 8] = b;
            end
        end
        i2c_stop();
    endtask

    task automatic check_reset(input string name);
        check(name, {sda_o, scl_o, rx_data, rx_valid, tx_req, busy, rw, start_det, stop_det, nack_det},
              {1'b1, 1'b1, 8'h00, 7'b0000000});
    endtask

    typedef struct packed {
        logic [6:0]  addr;
        logic [2:0]  n;
        logic [31:0] dat;
        logic [3:0]  rdy;
        logic        exp_aack;
        logic [3:0]  exp_ack;
        logic [2:0]  exp_rx;
    } wvec_t;

    wvec_t      vt [6];
    wvec_t      t;
    logic       aack, busy_at, ack1;
    logic [3:0] backs, rdy, exp_ack;
    logic [31:0] dat, got, exp_got;
    logic [6:0] a;
    logic [7:0] b8;
    logic [7:0] exp_rx[$];
    int rx0, st0, sl0, bz0, nk0, s0, n;
    logic acc, rnw;

    initial begin
        vt[0] = '{7'h50, 3'd2, 32'hA53C_0000, 4'b0011, 1'b1, 4'b0011, 3'd2};
        vt[1] = '{7'h51, 3'd2, 32'h1234_0000, 4'b0011, 1'b0, 4'b0000, 3'd0};
        vt[2] = '{7'h50, 3'd3, 32'h1122_3300, 4'b0110, 1'b1, 4'b0000, 3'd1};
        vt[3] = '{7'h50, 3'd1, 32'h5A00_0000, 4'b0001, 1'b1, 4'b0001, 3'd1};
        vt[4] = '{7'h28, 3'd1, 32'hFF00_0000, 4'b0001, 1'b0, 4'b0000, 3'd0};
        vt[5] = '{7'h50, 3'd3, 32'hC0FF_EE00, 4'b0011, 1'b1, 4'b0011, 3'd3};

        clks(3);
        check_reset("in_reset");
        reset = 1'b0;
        clks(2);
        check_reset("after_reset");

        for (int v = 0; v < 6; v++) begin
            t   = vt[v];
            rx0 = rx_got.size(); st0 = n_stop; sl0 = n_sda_low; bz0 = n_busy;
            do_write(t.addr, int'(t.n), t.dat, t.rdy, aack, busy_at, backs);
            check($sformatf("v%0d_addr_ack", v), aack, t.exp_aack);
            check($sformatf("v%0d_busy_addr", v), busy_at, t.exp_aack);
            check($sformatf("v%0d_byte_acks", v), backs, t.exp_ack);
            check($sformatf("v%0d_rx_cnt", v), rx_got.size() - rx0, t.exp_rx);
            for (int k = 0; k < int'(t.exp_rx); k++)
                if (rx0 + k < rx_got.size())
                    check($sformatf("v%0d_rx_data%0d", v, k), rx_got[rx0+k], t.dat[31-8*k -: 8]);
            check($sformatf("v%0d_stop_det", v), n_stop - st0, 1);
            check($sformatf("v%0d_busy_end", v), busy, 0);
            if (!t.exp_aack) begin
                check($sformatf("v%0d_sda_driven", v), n_sda_low - sl0, 0);
                check($sformatf("v%0d_busy_cycles", v), n_busy - bz0, 0);
            end
        end

        // Read 0x96 with data arriving 20 clk after the request
        tx_delay = 20; tx_buf[tx_wr] = 8'h96; tx_wr++;
        nk0 = n_nack;
        do_read(7'h50, 1, aack, got);
        check("rd_addr_ack", aack, 1);
        check("rd_data", got[31:24], 8'h96);
        check("rd_stretch_len", stretch_len, tx_delay + 2);
        check("rd_setup_bit7", stretch_sda, 1'b1);
        check("rd_nack_det", n_nack - nk0, 1);
        check("rd_busy_end", busy, 0);

        // Repeated START after a write byte, then a read
        rx0 = rx_got.size();
        i2c_start();
        write_byte(8'hA0, ack1);
        write_byte(8'h77, aack);
        check("rs_wr_ack", {ack1, aack}, 2'b11);
        s0 = n_start;
        tx_delay = 30; tx_buf[tx_wr] = 8'hC3; tx_wr++;
        i2c_start();
        check("rs_start_det", n_start - s0, 1);
        write_byte(8'hA1, aack);
        check("rs_rd_ack", aack, 1);
        clks(2);
        check("rs_rw_busy_req", {rw, busy, tx_req}, 3'b111);
        read_byte(1'b1, b8);
        check("rs_rd_data", b8, 8'hC3);
        i2c_stop();
        check("rs_rx_byte", (rx_got.size() > rx0) ? rx_got[rx0] : 8'h00, 8'h77);

        // Random transactions against a byte-level model
        for (int r = 0; r < 10; r++) begin
            a   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h50;
            n   = $urandom_range(1, 3);
            rnw = 1'($urandom_range(0, 1));
            if (!rnw) begin
                dat = $urandom();
                rdy = 4'($urandom_range(0, 15));
                acc = (a == 7'h50);
                exp_ack = 4'b0000;
                exp_rx.delete();
                for (int i = 0; i < n; i++) begin
                    exp_ack[i] = acc & rdy[i];
                    if (acc) exp_rx.push_back(dat[31-8*i -: 8]);
                    acc = acc & rdy[i];
                end
                rx0 = rx_got.size(); st0 = n_stop;
                do_write(a, n, dat, rdy, aack, busy_at, backs);
                check($sformatf("r%0d_wr_addr_ack", r), aack, a == 7'h50);
                check($sformatf("r%0d_wr_acks", r), backs, exp_ack);
                check($sformatf("r%0d_rx_cnt", r), rx_got.size() - rx0, exp_rx.size());
                for (int k = 0; k < exp_rx.size(); k++)
                    if (rx0 + k < rx_got.size())
                        check($sformatf("r%0d_rx_data%0d", r, k), rx_got[rx0+k], exp_rx[k]);
                check($sformatf("r%0d_stop", r), n_stop - st0, 1);
            end else begin
                tx_delay = $urandom_range(0, 5);
                exp_got = 32'h0;
                if (a == 7'h50) begin
                    for (int i = 0; i < n; i++) begin
                        b8 = 8'($urandom());
                        exp_got[31-8*i -: 8] = b8;
                        tx_buf[tx_wr] = b8; tx_wr++;
                    end
                end
                nk0 = n_nack;
                do_read(a, n, aack, got);
                check($sformatf("r%0d_rd_addr_ack", r), aack, a == 7'h50);
                check($sformatf("r%0d_rd_data", r), got, exp_got);
                check($sformatf("r%0d_nack_det", r), n_nack - nk0, a == 7'h50);
            end
            check($sformatf("r%0d_busy_end", r), busy, 0);
        end

        // Reset while a read byte is being shifted out
        tx_delay = 0; tx_buf[tx_wr] = 8'h00; tx_wr++;
        i2c_start();
        write_byte(8'hA1, aack);
        check("mr_addr_ack", aack, 1);
        for (int i = 0; i < 3; i++) read_bit(ack1);
        check("mr_sda_driven", sda_o, 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset("mid_read_reset");
        reset = 1'b0;
        i2c_stop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
